// File: rtl/soft_mute.sv
`default_nettype none
// ============================================================================
// soft_mute : click-free multichannel mute using a shared linear gain ramp
// Revision 1.0
// ============================================================================
module soft_mute #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 2,
  parameter int RAMP_LOG2   = 6,
  parameter int START_MUTED = 0
) (
  input  logic                      clk_48,
  input  logic                      reset,
  input  logic                      mute,
  input  logic [CHANNELS*WIDTH-1:0] muteIn,
  output logic [CHANNELS*WIDTH-1:0] muteOut,
  output logic                      muted,
  output logic                      ramping
);

  localparam int                 PW      = WIDTH + RAMP_LOG2 + 2;
  localparam logic [RAMP_LOG2:0] GMAX    = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [RAMP_LOG2:0] GONE    = {{RAMP_LOG2{1'b0}}, 1'b1};
  localparam logic [RAMP_LOG2:0] GZERO   = '0;
  localparam logic [RAMP_LOG2:0] G_RESET = (START_MUTED != 0) ? GZERO : GMAX;

  logic [RAMP_LOG2:0]          g_q, g_d;
  logic [CHANNELS*WIDTH-1:0]   muteOut_q, muteOut_d;
  logic                        muted_q, ramping_q;

  always_comb begin
    g_d = g_q;
    if (mute) begin
      if (g_q != GZERO) g_d = g_q - GONE;
    end else if (g_q != GMAX) begin
      g_d = g_q + GONE;
    end
  end

  // Products use the gain before this edge's update; the shifted slice is an
  // arithmetic shift right (floor) truncated to WIDTH, which cannot overflow.
  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic signed [PW-1:0] x_ext;
      logic signed [PW-1:0] g_ext;
      logic signed [PW-1:0] prod;
      logic                 unused_bits;

      assign x_ext = {{(RAMP_LOG2+2){muteIn[c*WIDTH+WIDTH-1]}}, muteIn[c*WIDTH +: WIDTH]};
      assign g_ext = {{(WIDTH+1){1'b0}}, g_q};
      assign prod  = x_ext * g_ext;
      assign muteOut_d[c*WIDTH +: WIDTH] = prod[RAMP_LOG2 +: WIDTH];
      assign unused_bits = ^{prod[PW-1 -: 2], prod[RAMP_LOG2-1:0]};
    end
  endgenerate

  always_ff @(posedge clk_48) begin
    if (reset) begin
      g_q       <= G_RESET;
      muteOut_q <= '0;
      muted_q   <= (START_MUTED != 0);
      ramping_q <= 1'b0;
    end else begin
      g_q       <= g_d;
      muteOut_q <= muteOut_d;
      muted_q   <= (g_d == GZERO);
      ramping_q <= (g_d != GZERO) && (g_d != GMAX);
    end
  end

  assign muteOut = muteOut_q;
  assign muted   = muted_q;
  assign ramping = ramping_q;

endmodule
`default_nettype wire

// File: tb/tb_soft_mute.sv
`default_nettype none
// tb_soft_mute : scoreboard bench for soft_mute (GMAX=64), plus a START_MUTED=1 instance.
module tb_soft_mute;

  logic        clk_48 = 1'b0;
  logic        reset  = 1'b1;
  logic        mute   = 1'b0;
  logic [31:0] muteIn = '0;
  logic [31:0] muteOut, muteOut1;
  logic        muted, ramping, muted1, ramping1;

  always #5 clk_48 = ~clk_48;

  soft_mute #(.WIDTH(16), .CHANNELS(2), .RAMP_LOG2(6), .START_MUTED(0)) dut0 (
    .clk_48(clk_48), .reset(reset), .mute(mute), .muteIn(muteIn),
    .muteOut(muteOut), .muted(muted), .ramping(ramping));

  soft_mute #(.WIDTH(16), .CHANNELS(2), .RAMP_LOG2(6), .START_MUTED(1)) dut1 (
    .clk_48(clk_48), .reset(reset), .mute(mute), .muteIn(muteIn),
    .muteOut(muteOut1), .muted(muted1), .ramping(ramping1));

  typedef struct packed {
    logic [31:0] out;
    logic        muted;
    logic        ramping;
  } exp_t;

  exp_t sb[$];
  int   g_m   = 64;
  int   tests = 0;
  int   fails = 0;

  // Reference: floor(x*g/64) using integer division with floor correction.
  function automatic logic [15:0] scale(input int x, input int g);
    int p, q;
    p = x * g;
    q = p / 64;
    if (p < 0 && (p % 64) != 0) q = q - 1;
    return q[15:0];
  endfunction

  task automatic drive(input logic m, input int a, input int b, input logic r);
    exp_t e;
    reset  = r;
    mute   = m;
    muteIn = {b[15:0], a[15:0]};
    if (r) begin
      g_m   = 64;
      e.out = '0;
    end else begin
      e.out = {scale(b, g_m), scale(a, g_m)};
      if (m && g_m > 0) g_m = g_m - 1;
      else if (!m && g_m < 64) g_m = g_m + 1;
    end
    e.muted   = (g_m == 0);
    e.ramping = (g_m > 0) && (g_m < 64);
    sb.push_back(e);
    @(posedge clk_48);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1234, -567, i < 2);
      e = sb.pop_front();
      tests++;
      if ({muteOut, muted, ramping} !== e) begin
        fails++;
        $display("FAIL reset i=%0d got %h want %h", i, {muteOut, muted, ramping}, e);
      end
    end
    tests++;
    if (muteOut !== 32'hFDC9_04D2) begin
      fails++;
      $display("FAIL reset_release got %h want %h", muteOut, 32'hFDC9_04D2);
    end
  endtask

  task automatic test_passthrough;
    exp_t e;
    int   a;
    drive(1'b0, 32767, -32768, 1'b0);
    e = sb.pop_front();
    tests++;
    if ({muteOut, muted, ramping} !== e || muteOut !== 32'h8000_7FFF) begin
      fails++;
      $display("FAIL passthrough_fullscale got %h want %h", muteOut, 32'h8000_7FFF);
    end
    for (int i = 0; i < 48; i++) begin
      a = int'(20000.0 * $sin(2.0 * 3.14159265358979 * i / 48.0));
      drive(1'b0, a, -a, 1'b0);
      e = sb.pop_front();
      tests++;
      if ({muteOut, muted, ramping} !== e || muteOut[15:0] !== a[15:0]) begin
        fails++;
        $display("FAIL sine i=%0d got %h want %h", i, {muteOut, muted, ramping}, e);
      end
    end
  endtask

  task automatic test_ramp_down;
    exp_t        e;
    logic [15:0] w;
    for (int j = 0; j < 66; j++) begin
      drive(1'b1, 16384, 16384, 1'b0);
      e = sb.pop_front();
      w = (j < 64) ? 16'(16384 - 256 * j) : 16'h0000;
      tests++;
      if ({muteOut, muted, ramping} !== e ||
          {muteOut, muted, ramping} !== {w, w, (j >= 63), (j < 63)}) begin
        fails++;
        $display("FAIL ramp_down j=%0d got %h want %h", j, {muteOut, muted, ramping}, {w, w, j >= 63, j < 63});
      end
    end
  endtask

  task automatic test_reversal;
    exp_t        e;
    logic [15:0] w;
    for (int j = 0; j < 84; j++) begin
      drive(!(j >= 64 && j < 84 - 20 + 20 && j < 84) ? 1'b0 : (j < 84 && j >= 64 && j < 84) ? 1'b1 : 1'b0,
            16384, 16384, 1'b0);
      e = sb.pop_front();
      tests++;
      if ({muteOut, muted, ramping} !== e) begin
        fails++;
        $display("FAIL reversal_prep j=%0d got %h want %h", j, {muteOut, muted, ramping}, e);
      end
    end
    for (int i = 0; i < 21; i++) begin
      drive(1'b0, 16384, 16384, 1'b0);
      e = sb.pop_front();
      w = (i < 20) ? 16'(256 * (44 + i)) : 16'd16384;
      tests++;
      if ({muteOut, muted, ramping} !== e ||
          {muteOut[15:0], muted, ramping} !== {w, 1'b0, (i < 19)}) begin
        fails++;
        $display("FAIL reversal i=%0d got %h want %h", i, {muteOut[15:0], muted, ramping}, {w, 1'b0, i < 19});
      end
    end
  endtask

  task automatic test_rounding;
    exp_t e;
    for (int j = 0; j < 32; j++) begin
      drive(1'b1, 100, -100, 1'b0);
      e = sb.pop_front();
      tests++;
      if ({muteOut, muted, ramping} !== e) begin
        fails++;
        $display("FAIL round_prep j=%0d got %h want %h", j, {muteOut, muted, ramping}, e);
      end
    end
    drive(1'b0, -1, 1, 1'b0);
    e = sb.pop_front();
    tests++;
    if ({muteOut, muted, ramping} !== e || muteOut !== 32'h0000_FFFF) begin
      fails++;
      $display("FAIL round_small got %h want %h", muteOut, 32'h0000_FFFF);
    end
    drive(1'b1, 0, 0, 1'b0);
    e = sb.pop_front();
    drive(1'b0, -32768, 32767, 1'b0);
    e = sb.pop_front();
    tests++;
    if ({muteOut, muted, ramping} !== e || muteOut !== 32'h3FFF_C000) begin
      fails++;
      $display("FAIL round_large got %h want %h", muteOut, 32'h3FFF_C000);
    end
    for (int j = 0; j < 40; j++) begin
      drive((j < 8) ? j[0] : 1'b0, 3000, -3000, 1'b0);
      e = sb.pop_front();
      tests++;
      if ({muteOut, muted, ramping} !== e) begin
        fails++;
        $display("FAIL toggle j=%0d got %h want %h", j, {muteOut, muted, ramping}, e);
      end
    end
  endtask

  task automatic test_reset_mid_ramp;
    exp_t        e;
    logic [15:0] w;
    for (int j = 0; j < 34; j++) begin
      drive(1'b1, 16384, 16384, 1'b0);
      e = sb.pop_front();
    end
    drive(1'b1, 16384, 16384, 1'b1);
    e = sb.pop_front();
    tests++;
    if ({muteOut, muted, ramping} !== e || {muteOut, muted, ramping} !== 34'd0) begin
      fails++;
      $display("FAIL reset_mid got %h want %h", {muteOut, muted, ramping}, 34'd0);
    end
    for (int j = 0; j < 65; j++) begin
      drive(1'b1, 16384, 16384, 1'b0);
      e = sb.pop_front();
      w = (j < 64) ? 16'(16384 - 256 * j) : 16'h0000;
      tests++;
      if ({muteOut, muted, ramping} !== e || {muteOut[15:0], muted} !== {w, (j >= 63)}) begin
        fails++;
        $display("FAIL fresh_ramp j=%0d got %h want %h", j, {muteOut[15:0], muted}, {w, j >= 63});
      end
    end
  endtask

  task automatic test_start_muted;
    exp_t        e;
    logic [15:0] w;
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 16384, 16384, j < 2);
      e = sb.pop_front();
      tests++;
      if ({muteOut1, muted1, ramping1} !== {32'd0, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL start_muted_hold j=%0d got %h want %h", j, {muteOut1, muted1, ramping1}, {32'd0, 2'b10});
      end
    end
    for (int j = 0; j < 66; j++) begin
      drive(1'b0, 16384, 16384, 1'b0);
      e = sb.pop_front();
      w = 16'(256 * ((j < 64) ? j : 64));
      tests++;
      if ({muteOut1, muted1, ramping1} !== {w, w, 1'b0, (j < 63)}) begin
        fails++;
        $display("FAIL start_muted_up j=%0d got %h want %h", j, {muteOut1, muted1, ramping1}, {w, w, 1'b0, j < 63});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk_48);
    #1;
    test_reset();
    test_passthrough();
    test_ramp_down();
    test_reversal();
    test_rounding();
    test_reset_mid_ramp();
    test_start_muted();
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
